// File: rtl/room_controller.sv
// room_controller: tracks the current dungeon room and sequences the
// fade-out / room-swap / fade-in transition when the player exits through a door.
module room_controller #(
  parameter logic [2:0] START_ROOM  = 3'd0,
  parameter int         N_EDGE      = 32,
  parameter int         S_EDGE      = 448,
  parameter int         W_EDGE      = 0,
  parameter int         E_EDGE      = 608,
  parameter int         SPAWN_INSET = 64
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic [2:0] room,
  output logic       transition_active,
  output logic [3:0] fade_level,
  output logic       player_set,
  output logic [9:0] spawn_x,
  output logic [9:0] spawn_y
);

  typedef enum logic [1:0] {IDLE, FADE_OUT, SWAP, FADE_IN} state_t;

  localparam logic [9:0] N_LIM   = 10'(N_EDGE);
  localparam logic [9:0] S_LIM   = 10'(S_EDGE);
  localparam logic [9:0] W_LIM   = 10'(W_EDGE);
  localparam logic [9:0] E_LIM   = 10'(E_EDGE);
  localparam logic [9:0] SPAWN_N = 10'(S_EDGE - SPAWN_INSET);
  localparam logic [9:0] SPAWN_S = 10'(N_EDGE + SPAWN_INSET);
  localparam logic [9:0] SPAWN_W = 10'(E_EDGE - SPAWN_INSET);
  localparam logic [9:0] SPAWN_E = 10'(W_EDGE + SPAWN_INSET);

  state_t     state_reg, state_next;
  logic [2:0] room_reg, room_next;
  logic [2:0] next_room_reg, next_room_next;
  logic [3:0] fade_reg, fade_next;
  logic [9:0] spawn_x_reg, spawn_x_next;
  logic [9:0] spawn_y_reg, spawn_y_next;
  logic       frame_clk_q_reg;
  logic       tick;

  logic       trig_n, trig_s, trig_w, trig_e;
  logic       nb_valid;
  logic [2:0] nb_room;
  logic [9:0] cand_x, cand_y;

  assign tick   = frame_clk & ~frame_clk_q_reg;
  assign trig_n = (player_y <= N_LIM);
  assign trig_s = (player_y >= S_LIM);
  assign trig_w = (player_x <= W_LIM);
  assign trig_e = (player_x >= E_LIM);

  // Door lookup: only the highest-priority trigger (N > S > W > E) is consulted.
  always_comb begin
    nb_valid = 1'b0;
    nb_room  = 3'd0;
    cand_x   = player_x;
    cand_y   = player_y;
    if (trig_n) begin
      cand_y = SPAWN_N;
      case (room_reg)
        3'd0: begin nb_valid = 1'b1; nb_room = 3'd2; end
        3'd4: begin nb_valid = 1'b1; nb_room = 3'd3; end
        3'd5: begin nb_valid = 1'b1; nb_room = 3'd6; end
        default: ;
      endcase
    end else if (trig_s) begin
      cand_y = SPAWN_S;
      case (room_reg)
        3'd2: begin nb_valid = 1'b1; nb_room = 3'd0; end
        3'd3: begin nb_valid = 1'b1; nb_room = 3'd4; end
        3'd6: begin nb_valid = 1'b1; nb_room = 3'd5; end
        default: ;
      endcase
    end else if (trig_w) begin
      cand_x = SPAWN_W;
      case (room_reg)
        3'd0: begin nb_valid = 1'b1; nb_room = 3'd1; end
        3'd1: begin nb_valid = 1'b1; nb_room = 3'd3; end
        3'd4: begin nb_valid = 1'b1; nb_room = 3'd5; end
        3'd5: begin nb_valid = 1'b1; nb_room = 3'd7; end
        default: ;
      endcase
    end else if (trig_e) begin
      cand_x = SPAWN_E;
      case (room_reg)
        3'd1: begin nb_valid = 1'b1; nb_room = 3'd0; end
        3'd3: begin nb_valid = 1'b1; nb_room = 3'd1; end
        3'd5: begin nb_valid = 1'b1; nb_room = 3'd4; end
        3'd7: begin nb_valid = 1'b1; nb_room = 3'd5; end
        default: ;
      endcase
    end
  end

  // Transition sequencer: next-state and next-value logic.
  always_comb begin
    state_next     = state_reg;
    room_next      = room_reg;
    next_room_next = next_room_reg;
    fade_next      = fade_reg;
    spawn_x_next   = spawn_x_reg;
    spawn_y_next   = spawn_y_reg;
    case (state_reg)
      IDLE: begin
        if (tick && nb_valid) begin
          next_room_next = nb_room;
          spawn_x_next   = cand_x;
          spawn_y_next   = cand_y;
          state_next     = FADE_OUT;
        end
      end
      FADE_OUT: begin
        if (tick) begin
          if (fade_reg == 4'd15) state_next = SWAP;
          else                   fade_next  = fade_reg + 4'd1;
        end
      end
      SWAP: begin
        room_next  = next_room_reg;
        state_next = FADE_IN;
      end
      FADE_IN: begin
        if (tick) begin
          if (fade_reg == 4'd0) state_next = IDLE;
          else                  fade_next  = fade_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; history starts high so reset never fakes a tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg       <= IDLE;
      room_reg        <= START_ROOM;
      next_room_reg   <= START_ROOM;
      fade_reg        <= 4'd0;
      spawn_x_reg     <= 10'd0;
      spawn_y_reg     <= 10'd0;
      frame_clk_q_reg <= 1'b1;
    end else begin
      state_reg       <= state_next;
      room_reg        <= room_next;
      next_room_reg   <= next_room_next;
      fade_reg        <= fade_next;
      spawn_x_reg     <= spawn_x_next;
      spawn_y_reg     <= spawn_y_next;
      frame_clk_q_reg <= frame_clk;
    end
  end

  assign room              = room_reg;
  assign fade_level        = fade_reg;
  assign spawn_x           = spawn_x_reg;
  assign spawn_y           = spawn_y_reg;
  assign transition_active = (state_reg != IDLE);
  assign player_set        = (state_reg == SWAP);

endmodule

// File: tb/tb_room_controller.sv
// Directed testbench for room_controller.
module tb_room_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b1;
  logic [9:0] player_x = 10'd300;
  logic [9:0] player_y = 10'd224;
  logic [2:0] room;
  logic       transition_active;
  logic [3:0] fade_level;
  logic       player_set;
  logic [9:0] spawn_x;
  logic [9:0] spawn_y;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  logic [9:0] ps_x, ps_y;

  room_controller dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .player_x(player_x), .player_y(player_y),
    .room(room), .transition_active(transition_active),
    .fade_level(fade_level), .player_set(player_set),
    .spawn_x(spawn_x), .spawn_y(spawn_y)
  );

  always #10 Clk = ~Clk;

  // Record every respawn pulse together with the spawn point it carries.
  always @(negedge Clk) begin
    if (player_set) begin
      pulse_cnt = pulse_cnt + 1;
      ps_x = spawn_x;
      ps_y = spawn_y;
    end
  end

  // One frame tick: low then high on frame_clk; returns at a negedge after the tick edge.
  task automatic do_tick();
    @(negedge Clk) frame_clk = 1'b0;
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk);
  endtask

  task automatic center();
    player_x = 10'd300;
    player_y = 10'd224;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Full door transition from the current room; checks destination and spawn.
  task automatic go_through(input logic [9:0] x, input logic [9:0] y,
                            input int exp_room, input int exp_sx, input int exp_sy);
    int p0;
    p0 = pulse_cnt;
    player_x = x;
    player_y = y;
    do_tick();
    center();
    check("go_active", transition_active, 1);
    for (int i = 0; i < 32; i++) do_tick();
    check("go_room", room, exp_room);
    check("go_pulses", pulse_cnt - p0, 1);
    check("go_spawn_x", ps_x, exp_sx);
    check("go_spawn_y", ps_y, exp_sy);
    check("go_idle", transition_active, 0);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_room", room, 0);
    check("rst_fade", fade_level, 0);
    check("rst_active", transition_active, 0);
    check("rst_spawn_x", spawn_x, 0);
    check("rst_spawn_y", spawn_y, 0);
    check("rst_pulses", pulse_cnt, 0);
  endtask

  task automatic test_main();
    int bad;
    int p0;
    p0 = pulse_cnt;
    player_x = 10'd300;
    player_y = 10'd20;
    do_tick();
    center();
    check("main_fade_out_entry", transition_active, 1);
    check("main_fade0", fade_level, 0);
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      do_tick();
      if (fade_level !== 4'(k)) bad++;
    end
    check("main_fade_up_errs", bad, 0);
    check("main_room_before_swap", room, 0);
    do_tick();
    @(negedge Clk);
    check("main_room_after_swap", room, 2);
    check("main_pulses", pulse_cnt - p0, 1);
    check("main_spawn_x", ps_x, 300);
    check("main_spawn_y", ps_y, 384);
    check("main_fade15", fade_level, 15);
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      do_tick();
      if (fade_level !== 4'(15 - k) || transition_active !== 1'b1) bad++;
    end
    check("main_fade_down_errs", bad, 0);
    do_tick();
    check("main_idle", transition_active, 0);
    check("main_final_fade", fade_level, 0);
  endtask

  task automatic test_invalid_door();
    int act_seen;
    act_seen = 0;
    player_x = 10'd0;
    player_y = 10'd224;
    for (int i = 0; i < 20; i++) begin
      do_tick();
      if (transition_active) act_seen++;
    end
    center();
    check("inv_room", room, 2);
    check("inv_active_seen", act_seen, 0);
  endtask

  task automatic test_priority();
    go_through(10'd300, 10'd460, 0, 300, 96);
    go_through(10'd0,   10'd224, 1, 544, 224);
    go_through(10'd0,   10'd224, 3, 544, 224);
    go_through(10'd300, 10'd460, 4, 300, 96);
    go_through(10'd0,   10'd224, 5, 544, 224);
    go_through(10'd0,   10'd20,  6, 0, 384);
  endtask

  task automatic test_latch_spawn();
    int p0;
    go_through(10'd300, 10'd460, 5, 300, 96);
    go_through(10'd620, 10'd224, 4, 64, 224);
    go_through(10'd300, 10'd20,  3, 300, 384);
    go_through(10'd620, 10'd224, 1, 64, 224);
    p0 = pulse_cnt;
    player_x = 10'd620;
    player_y = 10'd224;
    do_tick();
    player_x = 10'd0;
    for (int i = 0; i < 32; i++) do_tick();
    check("latch_room", room, 0);
    check("latch_spawn_x", ps_x, 64);
    check("latch_spawn_y", ps_y, 224);
    check("latch_pulses", pulse_cnt - p0, 1);
    check("latch_idle", transition_active, 0);
    center();
  endtask

  task automatic test_reset_mid();
    int p0;
    go_through(10'd300, 10'd20, 2, 300, 384);
    player_x = 10'd300;
    player_y = 10'd460;
    do_tick();
    center();
    for (int i = 0; i < 8; i++) do_tick();
    check("mid_fade_before", fade_level, 8);
    p0 = pulse_cnt;
    Reset = 1'b1;
    @(negedge Clk);
    check("mid_room", room, 0);
    check("mid_fade", fade_level, 0);
    check("mid_active", transition_active, 0);
    check("mid_player_set", player_set, 0);
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) do_tick();
    check("mid_room_after", room, 0);
    check("mid_pulses_after", pulse_cnt - p0, 0);
    check("mid_active_after", transition_active, 0);
  endtask

  initial begin
    fork
      begin
        #5ms;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_main();
    test_invalid_door();
    test_priority();
    test_latch_spawn();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
